// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivSigned         = 1'b1;
  localparam logic DivUnsigned       = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < divisor_i always holds, so the MSB of the (WIDTH+1)-bit difference is its sign.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; result is {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  div_unit_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;

  always_comb begin
    sign1    = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    sign2    = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    op1_abs  = sign1 ? -bus.opdata1_i : bus.opdata1_i;
    op2_abs  = sign2 ? -bus.opdata2_i : bus.opdata2_i;
    quot_fix = neg_quot_q ? -dvd_q : dvd_q;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .rem_o     (rem_next),
    .q_o       (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          result_q <= '0;
          ready_q  <= DivResultNotReady;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            neg_quot_q <= sign1 ^ sign2;
            neg_rem_q  <= sign1;
            dvd_q      <= op1_abs;
            dvs_q      <= op2_abs;
            rem_q      <= '0;
            cnt_q      <= '0;
            state_q    <= (bus.opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          result_q <= '0;
          ready_q  <= DivResultReady;
          state_q  <= DivEnd;
        end
        DivOn: begin
          if (bus.annul_i) begin
            result_q <= '0;
            ready_q  <= DivResultNotReady;
            state_q  <= DivFree;
          end else if (cnt_q != CNT_W'(WIDTH)) begin
            // Dividend register shifts out its MSB and collects quotient bits at the bottom.
            rem_q <= rem_next;
            dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            result_q <= {rem_fix, quot_fix};
            ready_q  <= DivResultReady;
            state_q  <= DivEnd;
          end
        end
        DivEnd: begin
          if (bus.start_i == DivStop || bus.annul_i) begin
            result_q <= '0;
            ready_q  <= DivResultNotReady;
            state_q  <= DivFree;
          end
        end
        default: state_q <= DivFree;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule
